// File: rtl/qdr_lvds_pkg.sv
// Shared definitions for the 4-lane DA/DAFRAME/DACLK link (transmitter and receiver).
package qdr_lvds_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned WORD_W   = 14;
   localparam int unsigned PAD_W    = 2;
   localparam int unsigned NIBBLES  = 4;

   // DAFRAME level per nibble slot, MSB is nibble 0.
   localparam logic [NIBBLES-1:0] FRAME_PATTERN = 4'b1100;

   typedef enum logic [2:0] {
      HUNT,
      N0,
      N1,
      N2,
      N3
   } rx_state_t;

   // Expected DAFRAME level for nibble slot idx.
   function automatic logic frame_bit(input logic [1:0] idx);
      return FRAME_PATTERN[2'd3 - idx];
   endfunction

endpackage

// File: rtl/qdr_frame_rx_if.sv
// Link-side and delivery-side signals of the frame receiver.
interface qdr_frame_rx_if #(
   parameter int unsigned ERR_CNT_W = 8
);
   import qdr_lvds_pkg::*;

   logic                  DACLK;
   logic [NIBBLE_W-1:0]   DA;
   logic                  DAFRAME;

   logic [WORD_W-1:0]     data_out;
   logic                  data_valid;
   logic                  locked;
   logic                  frame_err;
   logic                  pad_err;
   logic [ERR_CNT_W-1:0]  err_count;

   // Master drives the link and observes the delivered words.
   modport master (
      output DACLK, DA, DAFRAME,
      input  data_out, data_valid, locked, frame_err, pad_err, err_count
   );

   // Slave is the receiver.
   modport slave (
      input  DACLK, DA, DAFRAME,
      output data_out, data_valid, locked, frame_err, pad_err, err_count
   );

endinterface

// File: rtl/qdr_sync.sv
// Multi-stage flop-chain synchroniser for asynchronous inputs.
module qdr_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [STAGES*WIDTH-1:0] chain_q;

   generate
      if (STAGES == 1) begin : g_single
         // Single-stage capture.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) chain_q <= '0;
            else       chain_q <= din;
         end
      end else begin : g_chain
         // Shift new sample in at the low end, oldest stage at the top.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) chain_q <= '0;
            else       chain_q <= {chain_q[(STAGES-1)*WIDTH-1:0], din};
         end
      end
   endgenerate

   assign dout = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/qdr_frame_rx.sv
// Receive side of the 4-lane link: synchronises DACLK/DA/DAFRAME, aligns on the frame
// marker and reassembles 14-bit words, reporting lock and frame/pad errors.
module qdr_frame_rx
   import qdr_lvds_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_WORDS  = 2,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input logic           clk,
   input logic           reset,
   qdr_frame_rx_if.slave link
);

   localparam int unsigned GOOD_W = $clog2(LOCK_WORDS + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_WORDS);
   localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   localparam int unsigned SYNC_W = NIBBLE_W + 2;

   logic [SYNC_W-1:0]    sync_in;
   logic [SYNC_W-1:0]    sync_out;
   logic                 s_daclk;
   logic                 s_frame;
   logic [NIBBLE_W-1:0]  s_da;

   logic                 daclk_prev_q;
   logic                 sample_evt;
   logic                 prev_frame_q;

   rx_state_t            state_q, state_d;
   logic                 store_n0, store_n1, store_n2;
   logic                 word_done;
   logic                 frame_err_d;

   logic [NIBBLE_W-1:0]  n0_q, n1_q, n2_q;
   logic [GOOD_W-1:0]    good_cnt_q;
   logic [GOOD_W-1:0]    good_inc;
   logic                 locked_q;
   logic                 deliver;

   logic [TMO_W-1:0]     tmo_cnt_q;
   logic                 tmo_hit;

   logic [WORD_W-1:0]    data_out_q;
   logic                 data_valid_q;
   logic                 pad_err_q;
   logic                 frame_err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   assign sync_in = {link.DACLK, link.DAFRAME, link.DA};

   qdr_sync #(
      .WIDTH  (SYNC_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sync_in),
      .dout  (sync_out)
   );

   assign s_daclk = sync_out[SYNC_W-1];
   assign s_frame = sync_out[SYNC_W-2];
   assign s_da    = sync_out[NIBBLE_W-1:0];

   // DACLK falling edge lands mid-nibble, where DA/DAFRAME are stable.
   assign sample_evt = daclk_prev_q & ~s_daclk;

   // Edge-detect history and previous-sample frame level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         daclk_prev_q <= 1'b0;
         prev_frame_q <= 1'b0;
      end else begin
         daclk_prev_q <= s_daclk;
         if (sample_evt) prev_frame_q <= s_frame;
      end
   end

   // Counter reaches TMO_MAX on this cycle; a sample event in the same cycle takes priority.
   assign tmo_hit = !sample_evt && (tmo_cnt_q == TMO_LAST);

   // Timeout counter: cleared by each sample event, holds once it reaches the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
      end else if (sample_evt) begin
         tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != TMO_MAX) begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
   end

   // Alignment FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= HUNT;
      else       state_q <= state_d;
   end

   // Next-state: check each sampled DAFRAME level against the marker pattern.
   always_comb begin
      state_d     = state_q;
      store_n0    = 1'b0;
      store_n1    = 1'b0;
      store_n2    = 1'b0;
      word_done   = 1'b0;
      frame_err_d = 1'b0;
      if (sample_evt) begin
         case (state_q)
            HUNT: begin
               if (s_frame && !prev_frame_q) begin
                  store_n0 = 1'b1;
                  state_d  = N1;
               end
            end
            N0: begin
               if (s_frame == frame_bit(2'd0)) begin
                  store_n0 = 1'b1;
                  state_d  = N1;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            N1: begin
               if (s_frame == frame_bit(2'd1)) begin
                  store_n1 = 1'b1;
                  state_d  = N2;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            N2: begin
               if (s_frame == frame_bit(2'd2)) begin
                  store_n2 = 1'b1;
                  state_d  = N3;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            N3: begin
               if (s_frame == frame_bit(2'd3)) begin
                  word_done = 1'b1;
                  state_d   = N0;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end else if (tmo_hit && (state_q != HUNT)) begin
         frame_err_d = 1'b1;
         state_d     = HUNT;
      end
   end

   // Nibble capture; the last nibble is taken straight from the synchroniser.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n0_q <= '0;
         n1_q <= '0;
         n2_q <= '0;
      end else begin
         if (store_n0) n0_q <= s_da;
         if (store_n1) n1_q <= s_da;
         if (store_n2) n2_q <= s_da;
      end
   end

   assign good_inc = (good_cnt_q == LOCK_TGT) ? good_cnt_q : good_cnt_q + GOOD_W'(1);
   // The word that brings good_cnt to the target is already delivered.
   assign deliver  = word_done && (good_inc == LOCK_TGT);

   // Lock tracking: any frame error drops lock and restarts the good-word count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         good_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else if (frame_err_d) begin
         good_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else if (word_done) begin
         good_cnt_q <= good_inc;
         locked_q   <= (good_inc == LOCK_TGT);
      end
   end

   // Word delivery; data_out holds the last delivered word between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         pad_err_q    <= 1'b0;
      end else begin
         data_valid_q <= deliver;
         pad_err_q    <= deliver && (s_da[PAD_W-1:0] != '0);
         if (deliver) data_out_q <= {n0_q, n1_q, n2_q, s_da[NIBBLE_W-1:PAD_W]};
      end
   end

   // Frame error pulse and saturating error counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         frame_err_q <= frame_err_d;
         if (frame_err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign link.data_out   = data_out_q;
   assign link.data_valid = data_valid_q;
   assign link.locked     = locked_q;
   assign link.frame_err  = frame_err_q;
   assign link.pad_err    = pad_err_q;
   assign link.err_count  = err_cnt_q;

endmodule

// File: tb/tb_qdr_frame_rx.sv
// Directed bench for qdr_frame_rx: alignment, lock, pad/frame errors, timeout, reset, saturation.
module tb_qdr_frame_rx;
   import qdr_lvds_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   qdr_frame_rx_if #(.ERR_CNT_W(8)) link ();

   qdr_frame_rx #(
      .SYNC_STAGES (2),
      .LOCK_WORDS  (2),
      .TIMEOUT_CYC (64),
      .ERR_CNT_W   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .link  (link)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_fail    = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   logic [13:0] got_data[$];
   logic        got_pad[$];

   // Record delivered words and frame-error pulses away from the active edge.
   always @(negedge clk) begin
      if (link.data_valid) begin
         got_data.push_back(link.data_out);
         got_pad.push_back(link.pad_err);
         valid_cnt++;
      end
      if (link.frame_err) ferr_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One nibble: DACLK high 3 clk (data changes on rise), low 4 clk.
   task automatic send_nibble(input logic fr, input logic [3:0] nib);
      @(negedge clk);
      link.DA      = nib;
      link.DAFRAME = fr;
      link.DACLK   = 1'b1;
      repeat (3) @(negedge clk);
      link.DACLK = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_word(input logic [13:0] w, input logic [1:0] pad);
      send_nibble(1'b1, w[13:10]);
      send_nibble(1'b1, w[9:6]);
      send_nibble(1'b0, w[5:2]);
      send_nibble(1'b0, {w[1:0], pad});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      got_data.delete();
      got_pad.delete();
      valid_cnt = 0;
   endtask

   // Hard stop if the sequence ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      link.DACLK   = 1'b0;
      link.DA      = 4'h0;
      link.DAFRAME = 1'b0;
      reset = 1'b1;
      idle(3);
      check_val("rst_data_out", link.data_out, 0);
      check_val("rst_valid", link.data_valid, 0);
      check_val("rst_locked", link.locked, 0);
      check_val("rst_frame_err", link.frame_err, 0);
      check_val("rst_pad_err", link.pad_err, 0);
      check_val("rst_err_count", link.err_count, 0);
      reset = 1'b0;
      idle(4);

      // Acquire: first word discarded, second reaches lock and is delivered.
      repeat (3) send_word(14'h2A5C, 2'b00);
      idle(6);
      check_val("acq_valid_cnt", valid_cnt, 2);
      check_val("acq_data0", got_data[0], 14'h2A5C);
      check_val("acq_pad0", got_pad[0], 0);
      check_val("acq_locked", link.locked, 1);
      check_val("acq_err_count", link.err_count, 0);

      // Locked stream with pad bits: n3=F, n3=4 (clean pad), n3=5.
      clear_log();
      send_word(14'h3FFF, 2'b11);
      send_word(14'h0001, 2'b00);
      send_word(14'h0001, 2'b01);
      idle(6);
      check_val("str_valid_cnt", valid_cnt, 3);
      check_val("str_data0", got_data[0], 14'h3FFF);
      check_val("str_pad0", got_pad[0], 1);
      check_val("str_data1", got_data[1], 14'h0001);
      check_val("str_pad1", got_pad[1], 0);
      check_val("str_data2", got_data[2], 14'h0001);
      check_val("str_pad2", got_pad[2], 1);

      // DAFRAME low on nibble 1 breaks the frame.
      clear_log();
      ferr_cnt = 0;
      send_nibble(1'b1, 4'h1);
      send_nibble(1'b0, 4'h2);
      idle(4);
      check_val("fe_pulses", ferr_cnt, 1);
      check_val("fe_locked", link.locked, 0);
      check_val("fe_err_count", link.err_count, 1);
      check_val("fe_data_hold", link.data_out, 14'h0001);
      send_nibble(1'b0, 4'h3);
      send_nibble(1'b0, 4'h0);
      send_word(14'h1234, 2'b00);
      idle(6);
      check_val("fe_relock1_valid", valid_cnt, 0);
      check_val("fe_relock1_locked", link.locked, 0);
      send_word(14'h0ABC, 2'b00);
      idle(6);
      check_val("fe_relock2_valid", valid_cnt, 1);
      check_val("fe_relock2_data", got_data[0], 14'h0ABC);
      check_val("fe_relock2_locked", link.locked, 1);
      check_val("fe_no_extra", ferr_cnt, 1);

      // DACLK stalls: nothing before the limit, exactly one pulse after it.
      ferr_cnt = 0;
      idle(40);
      check_val("tmo_early_pulses", ferr_cnt, 0);
      check_val("tmo_early_locked", link.locked, 1);
      idle(60);
      check_val("tmo_pulses", ferr_cnt, 1);
      check_val("tmo_locked", link.locked, 0);
      check_val("tmo_err_count", link.err_count, 2);
      clear_log();
      send_word(14'h2222, 2'b00);
      send_word(14'h1F0F, 2'b00);
      idle(6);
      check_val("tmo_relock_valid", valid_cnt, 1);
      check_val("tmo_relock_data", got_data[0], 14'h1F0F);
      check_val("tmo_relock_locked", link.locked, 1);

      // Reset during nibble 2 of a word.
      send_nibble(1'b1, 4'h5);
      send_nibble(1'b1, 4'h6);
      @(negedge clk);
      link.DA      = 4'h7;
      link.DAFRAME = 1'b0;
      link.DACLK   = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_val("mrst_locked", link.locked, 0);
      check_val("mrst_data_out", link.data_out, 0);
      check_val("mrst_err_count", link.err_count, 0);
      check_val("mrst_valid", link.data_valid, 0);
      idle(2);
      reset = 1'b0;
      idle(1);
      link.DACLK = 1'b0;
      idle(3);
      send_nibble(1'b0, 4'h0);
      clear_log();
      send_word(14'h0555, 2'b00);
      idle(6);
      check_val("mrst_w1_valid", valid_cnt, 0);
      check_val("mrst_w1_locked", link.locked, 0);
      send_word(14'h1AAA, 2'b00);
      idle(6);
      check_val("mrst_w2_valid", valid_cnt, 1);
      check_val("mrst_w2_data", got_data[0], 14'h1AAA);
      check_val("mrst_w2_locked", link.locked, 1);

      // Alternating DAFRAME gives one frame error per nibble pair.
      ferr_cnt = 0;
      repeat (254) begin
         send_nibble(1'b1, 4'h0);
         send_nibble(1'b0, 4'h0);
      end
      idle(4);
      check_val("sat_254_count", link.err_count, 8'hFE);
      check_val("sat_254_pulses", ferr_cnt, 254);
      repeat (6) begin
         send_nibble(1'b1, 4'h0);
         send_nibble(1'b0, 4'h0);
      end
      idle(4);
      check_val("sat_260_count", link.err_count, 8'hFF);
      check_val("sat_260_pulses", ferr_cnt, 260);
      check_val("sat_locked", link.locked, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
